// File: rtl/shot_scheduler.sv
// shot_scheduler: projectile slot controller for the player sprite.
// Turns fire-key press edges into shots in a small pool of slots. A new shot
// starts at the player's position and heading. Every frame, each live shot
// moves one step and is retired when its lifetime runs out or it leaves the
// screen.
module shot_scheduler #(
   parameter int         NUM_SLOTS = 4,
   parameter int         COOLDOWN  = 8,
   parameter int         LIFETIME  = 60,
   parameter int         SHOT_STEP = 4,
   parameter int         X_MAX     = 639,
   parameter int         Y_MAX     = 479,
   parameter logic [7:0] FIRE_KEY  = 8'h2C
) (
   input  logic                      frame_clk,
   input  logic                      Reset,
   input  logic [63:0]               keycode,
   input  logic [9:0]                BallX,
   input  logic [9:0]                BallY,
   input  logic [5:0]                BallAngle,
   output logic [10*NUM_SLOTS-1:0]   ShotX,
   output logic [10*NUM_SLOTS-1:0]   ShotY,
   output logic [NUM_SLOTS-1:0]      ShotActive,
   output logic                      Fire,
   output logic                      CooldownBusy
);

   localparam int LIFE_W = $clog2(LIFETIME + 1);
   localparam int CD_W   = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

   localparam logic [9:0]        X_LIM     = 10'(X_MAX);
   localparam logic [9:0]        Y_LIM     = 10'(Y_MAX);
   localparam logic [9:0]        STEP_A    = 10'(SHOT_STEP);
   localparam logic [9:0]        STEP_D    = 10'(SHOT_STEP - 1);
   localparam logic [9:0]        NEG_A     = 10'd0 - STEP_A;
   localparam logic [9:0]        NEG_D     = 10'd0 - STEP_D;
   localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIFETIME);
   localparam logic [CD_W-1:0]   CD_INIT   = CD_W'(COOLDOWN);

   logic [9:0]           x_q    [NUM_SLOTS];
   logic [9:0]           x_d    [NUM_SLOTS];
   logic [9:0]           y_q    [NUM_SLOTS];
   logic [9:0]           y_d    [NUM_SLOTS];
   logic [2:0]           dir_q  [NUM_SLOTS];
   logic [2:0]           dir_d  [NUM_SLOTS];
   logic [LIFE_W-1:0]    life_q [NUM_SLOTS];
   logic [LIFE_W-1:0]    life_d [NUM_SLOTS];
   logic [9:0]           nx     [NUM_SLOTS];
   logic [9:0]           ny     [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] active_q, active_d;
   logic [NUM_SLOTS-1:0] spawn_sel;
   logic [CD_W-1:0]      cooldown_q, cooldown_d;
   logic                 fire_q, fire_d;
   logic                 busy_q, busy_d;
   logic                 pressed_q, pressed_d;
   logic                 fire_req, have_free, spawn;
   logic                 angle_unused;

   // Headings finer than one octant have no effect on a shot's motion.
   assign angle_unused = ^BallAngle[2:0];

   // Per-octant X step (screen Y grows downward).
   function automatic logic [9:0] step_dx(input logic [2:0] oct);
      case (oct)
         3'd0:    return STEP_A;
         3'd1:    return STEP_D;
         3'd2:    return 10'd0;
         3'd3:    return NEG_D;
         3'd4:    return NEG_A;
         3'd5:    return NEG_D;
         3'd6:    return 10'd0;
         default: return STEP_D;
      endcase
   endfunction

   // Per-octant Y step.
   function automatic logic [9:0] step_dy(input logic [2:0] oct);
      case (oct)
         3'd0:    return 10'd0;
         3'd1:    return STEP_D;
         3'd2:    return STEP_A;
         3'd3:    return STEP_D;
         3'd4:    return 10'd0;
         3'd5:    return NEG_D;
         3'd6:    return NEG_A;
         default: return NEG_D;
      endcase
   endfunction

   // Fire key seen in any of the eight report bytes; only a fresh press requests a shot.
   always_comb begin
      pressed_d = 1'b0;
      for (int b = 0; b < 8; b++) begin
         if (keycode[8*b +: 8] == FIRE_KEY) pressed_d = 1'b1;
      end
      fire_req = pressed_d & ~pressed_q;
   end

   // Lowest-index free slot, judged from registered activity so a slot retiring now is still busy.
   always_comb begin
      spawn_sel = '0;
      have_free = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!active_q[i] && !have_free) begin
            spawn_sel[i] = 1'b1;
            have_free    = 1'b1;
         end
      end
      // A count of 1 reaches zero on this same edge, so the reload may happen now.
      spawn = fire_req && have_free && (cooldown_q <= CD_W'(1));
   end

   // Candidate next position of every slot, wrapping in 10 bits so left/top exits land high.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         nx[i] = x_q[i] + step_dx(dir_q[i]);
         ny[i] = y_q[i] + step_dy(dir_q[i]);
      end
   end

   // Next state for every slot plus the cooldown counter and fire pulse.
   always_comb begin
      active_d = active_q;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         x_d[i]    = x_q[i];
         y_d[i]    = y_q[i];
         dir_d[i]  = dir_q[i];
         life_d[i] = life_q[i];
         if (spawn && spawn_sel[i]) begin
            x_d[i]      = BallX;
            y_d[i]      = BallY;
            dir_d[i]    = BallAngle[5:3];
            life_d[i]   = LIFE_INIT;
            active_d[i] = 1'b1;
         end else if (active_q[i]) begin
            if (life_q[i] == LIFE_W'(1)) begin
               active_d[i] = 1'b0;
            end else if ((nx[i] > X_LIM) || (ny[i] > Y_LIM)) begin
               active_d[i] = 1'b0;
            end else begin
               x_d[i]    = nx[i];
               y_d[i]    = ny[i];
               life_d[i] = life_q[i] - LIFE_W'(1);
            end
         end
      end

      cooldown_d = cooldown_q;
      if (spawn) begin
         cooldown_d = CD_INIT;
      end else if (cooldown_q != '0) begin
         cooldown_d = cooldown_q - CD_W'(1);
      end
      busy_d = (cooldown_d != '0);
      fire_d = spawn;
   end

   // State registers; reset clears every shot but still tracks the key so a held key cannot fire.
   always_ff @(posedge frame_clk) begin
      pressed_q <= pressed_d;
      if (Reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            x_q[i]    <= '0;
            y_q[i]    <= '0;
            dir_q[i]  <= '0;
            life_q[i] <= '0;
         end
         active_q   <= '0;
         cooldown_q <= '0;
         fire_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            x_q[i]    <= x_d[i];
            y_q[i]    <= y_d[i];
            dir_q[i]  <= dir_d[i];
            life_q[i] <= life_d[i];
         end
         active_q   <= active_d;
         cooldown_q <= cooldown_d;
         fire_q     <= fire_d;
         busy_q     <= busy_d;
      end
   end

   // Pack the slot registers onto the output buses.
   always_comb begin
      ShotX = '0;
      ShotY = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         ShotX[10*i +: 10] = x_q[i];
         ShotY[10*i +: 10] = y_q[i];
      end
   end

   assign ShotActive   = active_q;
   assign Fire         = fire_q;
   assign CooldownBusy = busy_q;

endmodule

// File: tb/tb_shot_scheduler.sv
// tb_shot_scheduler: directed vectors and hand-written sequences for shot_scheduler.
module tb_shot_scheduler;

   localparam logic [63:0] KEY_NONE = 64'h0;
   localparam logic [63:0] KEY_A    = 64'h0000_0000_0000_0004;
   localparam logic [63:0] KEY3     = 64'h0000_0000_2C00_0000;
   localparam logic [63:0] KEY7     = 64'h2C00_0000_0000_0000;

   logic        frame_clk;
   logic        Reset;
   logic [63:0] keycode;
   logic [9:0]  BallX, BallY;
   logic [5:0]  BallAngle;
   logic [39:0] ShotX, ShotY;
   logic [3:0]  ShotActive;
   logic        Fire, CooldownBusy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst;
      logic [63:0] key;
      logic [9:0]  bx;
      logic [9:0]  by;
      logic [5:0]  ang;
      logic [3:0]  act;
      logic        fire;
      logic        busy;
      logic [9:0]  x0;
      logic [9:0]  y0;
   } vec_t;

   vec_t vecs [12];

   shot_scheduler dut (
      .frame_clk    (frame_clk),
      .Reset        (Reset),
      .keycode      (keycode),
      .BallX        (BallX),
      .BallY        (BallY),
      .BallAngle    (BallAngle),
      .ShotX        (ShotX),
      .ShotY        (ShotY),
      .ShotActive   (ShotActive),
      .Fire         (Fire),
      .CooldownBusy (CooldownBusy)
   );

   // Free-running frame clock.
   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   function automatic logic [9:0] slotX(input int i);
      return ShotX[10*i +: 10];
   endfunction

   function automatic logic [9:0] slotY(input int i);
      return ShotY[10*i +: 10];
   endfunction

   // Drive one frame of inputs, let one edge pass, then settle before sampling.
   task automatic applyStimulus(input logic rst, input logic [63:0] key,
                                input logic [9:0] bx, input logic [9:0] by,
                                input logic [5:0] ang);
      Reset     = rst;
      keycode   = key;
      BallX     = bx;
      BallY     = by;
      BallAngle = ang;
      @(posedge frame_clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Expected slot occupancy during the fill/collision sequence.
   function automatic int fillMask(input int s);
      if (s < 8)        return 4'b0001;
      else if (s < 16)  return 4'b0011;
      else if (s < 24)  return 4'b0111;
      else if (s < 40)  return 4'b1111;
      else if (s < 42)  return 4'b1101;
      else              return 4'b1111;
   endfunction

   // Directed test sequence.
   initial begin
      int cd;
      logic exp_fire;
      logic [9:0] bx;

      vecs[0]  = '{1'b1, KEY_NONE, 10'd0,   10'd0,   6'd0,  4'b0000, 1'b0, 1'b0, 10'd0,   10'd0};
      vecs[1]  = '{1'b0, KEY_A,    10'd320, 10'd240, 6'd0,  4'b0000, 1'b0, 1'b0, 10'd0,   10'd0};
      vecs[2]  = '{1'b0, KEY3,     10'd320, 10'd240, 6'd0,  4'b0001, 1'b1, 1'b1, 10'd320, 10'd240};
      vecs[3]  = '{1'b0, KEY3,     10'd100, 10'd240, 6'd0,  4'b0001, 1'b0, 1'b1, 10'd324, 10'd240};
      vecs[4]  = '{1'b0, KEY3,     10'd100, 10'd240, 6'd0,  4'b0001, 1'b0, 1'b1, 10'd328, 10'd240};
      vecs[5]  = '{1'b0, KEY_NONE, 10'd100, 10'd240, 6'd0,  4'b0001, 1'b0, 1'b1, 10'd332, 10'd240};
      vecs[6]  = '{1'b0, KEY7,     10'd100, 10'd240, 6'd0,  4'b0001, 1'b0, 1'b1, 10'd336, 10'd240};
      vecs[7]  = '{1'b0, KEY_NONE, 10'd100, 10'd240, 6'd0,  4'b0001, 1'b0, 1'b1, 10'd340, 10'd240};
      vecs[8]  = '{1'b0, KEY_NONE, 10'd100, 10'd240, 6'd0,  4'b0001, 1'b0, 1'b1, 10'd344, 10'd240};
      vecs[9]  = '{1'b0, KEY_NONE, 10'd100, 10'd240, 6'd0,  4'b0001, 1'b0, 1'b1, 10'd348, 10'd240};
      vecs[10] = '{1'b0, KEY7,     10'd100, 10'd200, 6'd16, 4'b0011, 1'b1, 1'b1, 10'd352, 10'd240};
      vecs[11] = '{1'b0, KEY_NONE, 10'd100, 10'd200, 6'd16, 4'b0011, 1'b0, 1'b1, 10'd356, 10'd240};

      Reset = 1'b1; keycode = '0; BallX = '0; BallY = '0; BallAngle = '0;

      // Basic spawn, motion, held key and cooldown drop via the vector table.
      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].rst, vecs[v].key, vecs[v].bx, vecs[v].by, vecs[v].ang);
         checkOutput($sformatf("vec%0d active", v), int'(ShotActive),   int'(vecs[v].act));
         checkOutput($sformatf("vec%0d fire", v),   int'(Fire),         int'(vecs[v].fire));
         checkOutput($sformatf("vec%0d busy", v),   int'(CooldownBusy), int'(vecs[v].busy));
         checkOutput($sformatf("vec%0d x0", v),     int'(slotX(0)),     int'(vecs[v].x0));
         checkOutput($sformatf("vec%0d y0", v),     int'(slotY(0)),     int'(vecs[v].y0));
      end
      checkOutput("vec11 x1", int'(slotX(1)), 100);
      checkOutput("vec11 y1", int'(slotY(1)), 204);

      // Lifetime with diagonal motion while the key stays held.
      applyStimulus(1'b1, KEY_NONE, 10'd0, 10'd0, 6'd0);
      applyStimulus(1'b0, KEY3, 10'd100, 10'd100, 6'd8);
      checkOutput("life spawn fire", int'(Fire), 1);
      checkOutput("life spawn active", int'(ShotActive), 1);
      checkOutput("life spawn x", int'(slotX(0)), 100);
      for (int k = 1; k < 60; k++) begin
         applyStimulus(1'b0, KEY3, 10'd400, 10'd400, 6'd0);
         checkOutput($sformatf("life k=%0d active", k), int'(ShotActive), 1);
         checkOutput($sformatf("life k=%0d x", k), int'(slotX(0)), 100 + 3*k);
         checkOutput($sformatf("life k=%0d y", k), int'(slotY(0)), 100 + 3*k);
      end
      applyStimulus(1'b0, KEY3, 10'd400, 10'd400, 6'd0);
      checkOutput("life end active", int'(ShotActive), 0);
      checkOutput("life end x held", int'(slotX(0)), 277);
      checkOutput("life end y held", int'(slotY(0)), 277);

      // Cooldown, slot fill, full-pool drop and retire/spawn collision.
      applyStimulus(1'b1, KEY_NONE, 10'd0, 10'd0, 6'd0);
      cd = 0;
      for (int s = 0; s <= 42; s++) begin
         bx = (s == 8) ? 10'd512 : ((s == 42) ? 10'd20 : 10'd10);
         applyStimulus(1'b0, (s % 2 == 0) ? KEY3 : KEY_NONE, bx, 10'd50, 6'd0);
         exp_fire = (s == 0) || (s == 8) || (s == 16) || (s == 24) || (s == 42);
         if (exp_fire) cd = 8;
         else if (cd > 0) cd--;
         checkOutput($sformatf("fill s=%0d fire", s), int'(Fire), int'(exp_fire));
         checkOutput($sformatf("fill s=%0d active", s), int'(ShotActive), fillMask(s));
         checkOutput($sformatf("fill s=%0d busy", s), int'(CooldownBusy), int'(cd != 0));
         if (s == 40) checkOutput("fill slot1 x held", int'(slotX(1)), 636);
      end
      checkOutput("fill slot1 respawn x", int'(slotX(1)), 20);
      checkOutput("fill slot1 respawn y", int'(slotY(1)), 50);

      // Right-edge exit, then wrap-around exit off the top.
      applyStimulus(1'b1, KEY_NONE, 10'd0, 10'd0, 6'd0);
      applyStimulus(1'b0, KEY3, 10'd637, 10'd100, 6'd0);
      checkOutput("edge x spawn active", int'(ShotActive), 1);
      checkOutput("edge x spawn x", int'(slotX(0)), 637);
      applyStimulus(1'b0, KEY_NONE, 10'd0, 10'd0, 6'd0);
      checkOutput("edge x retire active", int'(ShotActive), 0);
      checkOutput("edge x retire x held", int'(slotX(0)), 637);
      for (int k = 2; k <= 7; k++) applyStimulus(1'b0, KEY_NONE, 10'd0, 10'd0, 6'd0);
      checkOutput("edge busy before reload", int'(CooldownBusy), 1);
      applyStimulus(1'b0, KEY3, 10'd300, 10'd2, 6'd48);
      checkOutput("edge y spawn fire", int'(Fire), 1);
      checkOutput("edge y spawn y", int'(slotY(0)), 2);
      applyStimulus(1'b0, KEY_NONE, 10'd0, 10'd0, 6'd0);
      checkOutput("edge y retire active", int'(ShotActive), 0);
      checkOutput("edge y retire y held", int'(slotY(0)), 2);

      // Mid-flight reset with the key held, then no fire until a fresh press.
      applyStimulus(1'b1, KEY_NONE, 10'd0, 10'd0, 6'd0);
      for (int s = 0; s < 20; s++) begin
         applyStimulus(1'b0, ((s % 8 == 0) || s > 16) ? KEY3 : KEY_NONE, 10'd30, 10'd40, 6'd16);
      end
      checkOutput("rst pre active", int'(ShotActive), 4'b0111);
      applyStimulus(1'b1, KEY3, 10'd30, 10'd40, 6'd16);
      checkOutput("rst active", int'(ShotActive), 0);
      checkOutput("rst fire", int'(Fire), 0);
      checkOutput("rst busy", int'(CooldownBusy), 0);
      checkOutput("rst x", int'(ShotX != 40'd0), 0);
      checkOutput("rst y", int'(ShotY != 40'd0), 0);
      for (int s = 0; s < 10; s++) begin
         applyStimulus(1'b0, KEY3, 10'd30, 10'd40, 6'd16);
         checkOutput($sformatf("rst hold s=%0d fire", s), int'(Fire), 0);
         checkOutput($sformatf("rst hold s=%0d active", s), int'(ShotActive), 0);
      end
      applyStimulus(1'b0, KEY_NONE, 10'd30, 10'd40, 6'd16);
      applyStimulus(1'b0, KEY3, 10'd30, 10'd40, 6'd16);
      checkOutput("rst repress fire", int'(Fire), 1);
      checkOutput("rst repress active", int'(ShotActive), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shot_scheduler.md
# shot_scheduler

Projectile slot controller for the player sprite. Detects fire-key presses from the USB keycode report, allocates one of `NUM_SLOTS` projectile slots, spawns each shot at the player's current position and heading, and moves and retires active shots once per frame. Sits beside the player-motion block on `frame_clk`. Its packed slot outputs feed the color mapper for drawing and the collision logic.

## Interface
- `NUM_SLOTS`, 4: number of projectile slots, 1–8.
- `COOLDOWN`, 8: frames between successive spawns.
- `LIFETIME`, 60: frames a shot stays active, ≥2.
- `SHOT_STEP`, 4: axial pixels per frame; each diagonal component is `SHOT_STEP-1`.
- `X_MAX`, 639: largest on-screen X.
- `Y_MAX`, 479: largest on-screen Y.
- `FIRE_KEY`, 8'h2C: HID usage code for fire (space).

Ports (one clock; reset is synchronous and active-high):
- `frame_clk`  in  1: frame clock; all state updates on its rising edge.
- `Reset`  in  1: synchronous, active-high.
- `keycode`  in  64: eight packed HID key bytes.
- `BallX`, `BallY`  in  10 each: current player center.
- `BallAngle`  in  6: player heading, 64 steps.
- `ShotX`, `ShotY`  out  10×NUM_SLOTS each: slot i occupies bits [10i+9:10i].
- `ShotActive`  out  NUM_SLOTS: slot i is live.
- `Fire`  out  1: one-frame pulse on spawn.
- `CooldownBusy`  out  1: high while the cooldown counter is nonzero.

## Operation
**Fire request**
- `pressed` = any `keycode` byte equals `FIRE_KEY`.
- `pressed_q` is a register holding `pressed` from the previous edge.
- `fire_req = pressed & ~pressed_q`, so a shot needs a press edge. Holding the key does not auto-fire.

**Spawn**
- A spawn happens when `fire_req`, cooldown is 0, and at least one slot has `ShotActive=0`.
- Free slots are judged from the registered `ShotActive` value. A slot retiring on this edge is not free until the next edge.
- The lowest-index free slot wins.
- On spawn the slot takes: X←`BallX`, Y←`BallY`, dir←`BallAngle[5:3]`, life←`LIFETIME`, active←1. Also cooldown←`COOLDOWN` and `Fire`←1.
- A request that is not granted (busy or all slots full) is dropped, not queued.

**Direction table** (octant, screen Y down; S=`SHOT_STEP`, D=S-1):
- 0: (+S, 0); 1: (+D, +D); 2: (0, +S); 3: (−D, +D)
- 4: (−S, 0); 5: (−D, −D); 6: (0, −S); 7: (+D, −D)

**Per-frame update** for each active slot not spawning on this edge:
- If life==1: active←0 (retire). Position holds its last value.
- Otherwise compute next = pos + delta in 10-bit two's complement, with wrap.
  - If nextX > `X_MAX` or nextY > `Y_MAX` (unsigned compare): retire. Negative wrap lands ≥1020, so left and top exits are caught by the same compare.
  - Otherwise pos←next and life←life−1.
- Inactive slots hold all their fields.

**Cooldown and Fire**
- Cooldown decrements by 1 per edge while nonzero. A spawn reload takes priority over the decrement.
- `Fire` is 0 on every edge without a spawn.

**Reset**
- All `ShotActive`=0, all X/Y=0, life=0, dir=0, cooldown=0, `Fire`=0, `CooldownBusy`=0.
- `pressed_q`←`pressed`, so a key held through reset does not fire on release of `Reset`.
- Reset asserted mid-flight clears every shot on that same edge.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Press first seen at edge N: slot active with spawn position, and `Fire`=1, after edge N. First move at edge N+1.
- A slot spawned at edge N has `ShotActive` high after edges N…N+`LIFETIME`−1, cleared at edge N+`LIFETIME`, with `LIFETIME`−1 moves. It may be cleared earlier by a boundary exit.
- Spawn at edge N with `COOLDOWN`=C: `CooldownBusy` is high after edges N…N+C−1. The earliest next spawn is at edge N+C.
- `BallX`, `BallY` and `BallAngle` are sampled only on the spawn edge. Later player motion does not affect the shot.

## Test plan
- **Basic spawn:** Reset, then BallX=320, BallY=240, BallAngle=0; press 0x2C in byte 3 at edge N. Expect slot0 active at (320,240), `Fire`=1 for one frame. Expect (324,240) after N+1, and (328,240) after N+2.
- **Lifetime and diagonal motion:** BallAngle=6'd8 (octant 1), hold the key. Expect exactly one shot moving +3/+3 per frame. With defaults, expect `ShotActive[0]` to fall after 60 frames while the shot is still on screen.
- **Cooldown and slot fill:** Give press edges every 2 frames. Expect only presses ≥8 frames apart to spawn, into slots 0,1,2,3 in order. With all slots full, expect a further press to be dropped with `Fire`=0.
- **Boundary retire:** Spawn at X=637, octant 0. Expect retirement on the first update (641 > 639) with X held at 637. Spawn at Y=2, octant 6. Expect retirement, since the wrap to 1022 exceeds 479.
- **Retire/spawn collision:** Fill all slots; a press lands on the edge where slot1 retires. Expect the press dropped, slot1 inactive. A press on the next eligible edge fills slot1.
- **Mid-flight reset:** Assert `Reset` for one edge while 3 shots are active and the key is held. Expect all outputs zero. Expect no spawn until the key is released and pressed again.
